// File: rtl/mm_stage_pkg.sv
// Shared definitions for the matching-memory stage: token and packet layout,
// FSM encodings and the stored-operand record.
package mm_stage_pkg;

  localparam int TOKEN_LENGTH  = 40;
  localparam int PACKET_LENGTH = 62;

  // Token field offsets
  localparam int OPC_HI   = 39;
  localparam int OPC_LO   = 34;
  localparam int PORT_BIT = 33;
  localparam int MONO_BIT = 32;
  localparam int TAG_HI   = 31;
  localparam int TAG_LO   = 16;
  localparam int DATA_HI  = 15;
  localparam int DATA_LO  = 0;

  // Packet field offsets
  localparam int DEST_HI   = 61;
  localparam int DEST_LO   = 40;
  localparam int P_OPC_HI  = 39;
  localparam int P_OPC_LO  = 34;
  localparam int DATAL_HI  = 31;
  localparam int DATAL_LO  = 16;
  localparam int DATAR_HI  = 15;
  localparam int DATAR_LO  = 0;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Everything kept per entry except the valid bit, which lives in flops
  typedef struct packed {
    logic [15:0] tag;
    logic        port;
    logic [5:0]  opc;
    logic [15:0] data;
  } mm_payload_t;

  function automatic logic [PACKET_LENGTH-1:0] make_packet(
    input logic [15:0] tag,
    input logic [5:0]  opc,
    input logic [15:0] data_l,
    input logic [15:0] data_r
  );
    return {6'b000000, tag, opc, 2'b00, data_l, data_r};
  endfunction

endpackage

// File: rtl/mm_entry_ram.sv
// Direct-mapped matching memory: valid flags with per-entry set/clear and a
// payload array with a synchronous write port and a combinational read.
module mm_entry_ram
  import mm_stage_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic                  rd_valid,
  output mm_payload_t           rd_payload,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  mm_payload_t           wr_payload,
  input  logic                  clr_en,
  input  logic [DEPTH_LOG2-1:0] clr_addr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  mm_payload_t      payload_mem [DEPTH];

  // Write and clear never target the same entry in one cycle: a store needs an
  // empty entry, a clear needs an occupied one (or the FSM is sweeping).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    assign valid_next[gi] =
      (wr_en  && wr_addr  == DEPTH_LOG2'(gi)) ? 1'b1 :
      (clr_en && clr_addr == DEPTH_LOG2'(gi)) ? 1'b0 :
      valid_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= valid_next;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      payload_mem[wr_addr] <= wr_payload;
    end
  end

  assign rd_valid   = valid_reg[rd_addr];
  assign rd_payload = payload_mem[rd_addr];

endmodule

// File: rtl/mm_stage.sv
// Matching-memory (firing) stage: pairs left/right operands by tag, fires
// monadic tokens directly, and presents one registered packet downstream.
module mm_stage
  import mm_stage_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                     CP,
  input  logic                     MR,
  input  logic [TOKEN_LENGTH-1:0]  TOKEN_IN,
  input  logic                     Send_in,
  output logic                     Ack_out,
  input  logic                     FLUSH,
  output logic [PACKET_LENGTH-1:0] PACKET_OUT,
  output logic                     Send_out,
  input  logic                     Ack_in,
  output logic                     COLLIDE,
  output logic [DEPTH_LOG2:0]      OCC
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [0:0]               state_reg, state_next;
  logic [DEPTH_LOG2-1:0]    ptr_reg, ptr_next;
  logic [DEPTH_LOG2:0]      occ_reg, occ_next;
  logic                     send_reg, send_next;
  logic [PACKET_LENGTH-1:0] packet_reg, packet_next;

  logic [5:0]  tok_opc;
  logic        tok_port;
  logic        tok_mono;
  logic [15:0] tok_tag;
  logic [15:0] tok_data;
  logic [DEPTH_LOG2-1:0] idx;

  logic        entry_valid;
  mm_payload_t entry;
  mm_payload_t wr_payload;

  logic run;
  logic pair_match;
  logic blocked;
  logic accept;
  logic fire_mono;
  logic fire_pair;
  logic store;
  logic clr_en;
  logic [DEPTH_LOG2-1:0] clr_addr;

  assign tok_opc  = TOKEN_IN[OPC_HI:OPC_LO];
  assign tok_port = TOKEN_IN[PORT_BIT];
  assign tok_mono = TOKEN_IN[MONO_BIT];
  assign tok_tag  = TOKEN_IN[TAG_HI:TAG_LO];
  assign tok_data = TOKEN_IN[DATA_HI:DATA_LO];
  assign idx      = tok_tag[DEPTH_LOG2-1:0];

  assign wr_payload = '{tag: tok_tag, port: tok_port, opc: tok_opc, data: tok_data};

  // During INIT the clear port follows the sweep pointer; in RUN it frees the
  // entry consumed by a firing pair.
  assign clr_en   = !run || fire_pair;
  assign clr_addr = run ? idx : ptr_reg;

  mm_entry_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk        (CP),
    .srst       (MR),
    .rd_addr    (idx),
    .rd_valid   (entry_valid),
    .rd_payload (entry),
    .wr_en      (store),
    .wr_addr    (idx),
    .wr_payload (wr_payload),
    .clr_en     (clr_en),
    .clr_addr   (clr_addr)
  );

  assign run        = (state_reg == ST_RUN);
  assign pair_match = entry_valid && (entry.tag == tok_tag) && (entry.port != tok_port);
  assign blocked    = !tok_mono && entry_valid && !pair_match;

  // Stale valid bits during the sweep are not reported as collisions.
  assign COLLIDE = run && Send_in && blocked;
  assign Ack_out = run && !COLLIDE && (!send_reg || Ack_in);

  assign accept    = Send_in && Ack_out;
  assign fire_mono = accept && tok_mono;
  assign fire_pair = accept && !tok_mono && pair_match;
  assign store     = accept && !tok_mono && !entry_valid;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    if (FLUSH) begin
      state_next = ST_INIT;
      ptr_next   = '0;
    end else if (!run) begin
      if (ptr_reg == DEPTH_LOG2'(DEPTH - 1)) begin
        state_next = ST_RUN;
      end else begin
        ptr_next = ptr_reg + 1'b1;
      end
    end
  end

  always_comb begin
    occ_next = occ_reg;
    if (FLUSH) begin
      occ_next = '0;
    end else if (store) begin
      occ_next = occ_reg + 1'b1;
    end else if (fire_pair) begin
      occ_next = occ_reg - 1'b1;
    end
  end

  // Operand order in the packet follows PORT, not arrival order.
  always_comb begin
    send_next   = send_reg;
    packet_next = packet_reg;
    if (fire_mono) begin
      send_next   = 1'b1;
      packet_next = make_packet(tok_tag, tok_opc, tok_data, 16'h0000);
    end else if (fire_pair) begin
      send_next = 1'b1;
      if (entry.port) begin
        packet_next = make_packet(tok_tag, entry.opc, tok_data, entry.data);
      end else begin
        packet_next = make_packet(tok_tag, entry.opc, entry.data, tok_data);
      end
    end else if (Ack_in) begin
      send_next = 1'b0;
    end
  end

  always_ff @(posedge CP) begin
    if (MR) begin
      state_reg  <= ST_INIT;
      ptr_reg    <= '0;
      occ_reg    <= '0;
      send_reg   <= 1'b0;
      packet_reg <= '0;
    end else begin
      state_reg  <= state_next;
      ptr_reg    <= ptr_next;
      occ_reg    <= occ_next;
      send_reg   <= send_next;
      packet_reg <= packet_next;
    end
  end

  assign Send_out   = send_reg;
  assign PACKET_OUT = packet_reg;
  assign OCC        = occ_reg;

endmodule

// File: tb/tb_mm_stage.sv
// Self-checking bench for mm_stage: directed scenarios plus a randomized run
// against a tag-indexed operand-store model of the firing rules.
module tb_mm_stage;

  localparam int DL    = 4;
  localparam int DEPTH = 16;

  logic        CP = 1'b0;
  logic        MR = 1'b1;
  logic [39:0] TOKEN_IN = '0;
  logic        Send_in = 1'b0;
  logic        Ack_out;
  logic        FLUSH = 1'b0;
  logic [61:0] PACKET_OUT;
  logic        Send_out;
  logic        Ack_in = 1'b0;
  logic        COLLIDE;
  logic [DL:0] OCC;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CP = ~CP;

  mm_stage #(.DEPTH_LOG2(DL)) dut (
    .CP         (CP),
    .MR         (MR),
    .TOKEN_IN   (TOKEN_IN),
    .Send_in    (Send_in),
    .Ack_out    (Ack_out),
    .FLUSH      (FLUSH),
    .PACKET_OUT (PACKET_OUT),
    .Send_out   (Send_out),
    .Ack_in     (Ack_in),
    .COLLIDE    (COLLIDE),
    .OCC        (OCC)
  );

  // ---------------- reference model ----------------
  bit          m_valid [DEPTH];
  logic [15:0] m_tag   [DEPTH];
  bit          m_port  [DEPTH];
  logic [5:0]  m_opc   [DEPTH];
  logic [15:0] m_data  [DEPTH];
  bit          m_out_v = 1'b0;
  logic [61:0] m_out   = '0;
  int          m_init_left = DEPTH;

  function automatic logic [39:0] mk_tok(input logic [5:0] opc, input logic port,
                                         input logic mono, input logic [15:0] tag,
                                         input logic [15:0] data);
    return {opc, port, mono, tag, data};
  endfunction

  function automatic logic [61:0] mk_pkt(input logic [15:0] tag, input logic [5:0] opc,
                                         input logic [15:0] dl, input logic [15:0] dr);
    return {6'b0, tag, opc, 2'b00, dl, dr};
  endfunction

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_valid[i]);
    return n;
  endfunction

  function automatic bit m_collide();
    logic [15:0] tag = TOKEN_IN[31:16];
    int i = int'(tag) % DEPTH;
    if (m_init_left != 0 || !Send_in || TOKEN_IN[32] || !m_valid[i]) return 1'b0;
    return !(m_tag[i] == tag && m_port[i] != TOKEN_IN[33]);
  endfunction

  function automatic bit m_ack();
    return (m_init_left == 0) && !m_collide() && (!m_out_v || Ack_in);
  endfunction

  function automatic void model_edge();
    logic [15:0] tag = TOKEN_IN[31:16];
    int i = int'(tag) % DEPTH;
    bit acc;
    if (MR) begin
      for (int k = 0; k < DEPTH; k++) m_valid[k] = 1'b0;
      m_out_v = 1'b0;
      m_out = '0;
      m_init_left = DEPTH;
      return;
    end
    acc = Send_in && m_ack();
    if (m_out_v && Ack_in) m_out_v = 1'b0;
    if (acc) begin
      if (TOKEN_IN[32]) begin
        m_out = mk_pkt(tag, TOKEN_IN[39:34], TOKEN_IN[15:0], 16'h0000);
        m_out_v = 1'b1;
      end else if (m_valid[i]) begin
        m_out = (m_port[i] == 1'b0) ? mk_pkt(tag, m_opc[i], m_data[i], TOKEN_IN[15:0])
                                    : mk_pkt(tag, m_opc[i], TOKEN_IN[15:0], m_data[i]);
        m_out_v = 1'b1;
        m_valid[i] = 1'b0;
      end else begin
        m_valid[i] = 1'b1;
        m_tag[i]   = tag;
        m_port[i]  = TOKEN_IN[33];
        m_opc[i]   = TOKEN_IN[39:34];
        m_data[i]  = TOKEN_IN[15:0];
      end
    end
    if (FLUSH) begin
      for (int k = 0; k < DEPTH; k++) m_valid[k] = 1'b0;
      m_init_left = DEPTH;
    end else if (m_init_left > 0) begin
      m_init_left--;
    end
  endfunction

  // ---------------- drivers ----------------
  task automatic drive(input logic [39:0] tok, input logic send, input logic ack,
                       input logic flush, input logic mr);
    @(negedge CP);
    TOKEN_IN = tok;
    Send_in  = send;
    Ack_in   = ack;
    FLUSH    = flush;
    MR       = mr;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge CP);
  endtask

  task automatic send_token(input logic [39:0] tok, input logic ack, input string name);
    int waited = 0;
    bit acc;
    forever begin
      drive(tok, 1'b1, ack, 1'b0, 1'b0);
      acc = m_ack();
      n_cmp++;
      if (Ack_out !== acc) begin
        n_err++;
        $display("FAIL %s_ack got=%b want=%b", name, Ack_out, acc);
      end
      tick();
      if (acc) begin
        $display("token %s %h accepted", name, tok);
        break;
      end
      waited++;
      if (waited > 40) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s_timeout got=no_accept want=accept", name);
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int low_cnt = 0;
    bit seen_high = 1'b0;
    drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive('0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    for (int c = 0; c < DEPTH + 4; c++) begin
      drive('0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (c == 0) begin
        n_cmp++;
        if (PACKET_OUT !== 62'h0) begin
          n_err++;
          $display("FAIL reset_packet got=%h want=0", PACKET_OUT);
        end
      end
      n_cmp++;
      if (Ack_out !== m_ack()) begin
        n_err++;
        $display("FAIL reset_ack c=%0d got=%b want=%b", c, Ack_out, m_ack());
      end
      n_cmp++;
      if (Send_out !== 1'b0 || OCC !== 5'd0) begin
        n_err++;
        $display("FAIL reset_idle c=%0d got send=%b occ=%0d want send=0 occ=0", c, Send_out, OCC);
      end
      if (!seen_high && Ack_out === 1'b0) low_cnt++;
      if (Ack_out === 1'b1) seen_high = 1'b1;
      tick();
    end
    n_cmp++;
    if (low_cnt != DEPTH) begin
      n_err++;
      $display("FAIL reset_init_len got=%0d want=%0d", low_cnt, DEPTH);
    end
    $display("reset: Ack_out low for %0d cycles", low_cnt);
  endtask

  task automatic test_pair(input logic first_port, input logic [15:0] tag,
                           input logic [5:0] opc_first, input logic [15:0] d_first,
                           input logic [15:0] d_second, input string name);
    logic [61:0] exp;
    exp = first_port ? mk_pkt(tag, opc_first, d_second, d_first)
                     : mk_pkt(tag, opc_first, d_first, d_second);
    send_token(mk_tok(opc_first, first_port, 1'b0, tag, d_first), 1'b1, name);
    drive('0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (OCC !== 5'd1 || Send_out !== 1'b0) begin
      n_err++;
      $display("FAIL %s_stored got occ=%0d send=%b want occ=1 send=0", name, OCC, Send_out);
    end
    tick();
    send_token(mk_tok(6'h3F, !first_port, 1'b0, tag, d_second), 1'b1, name);
    drive('0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (Send_out !== 1'b1 || PACKET_OUT !== exp || OCC !== 5'd0) begin
      n_err++;
      $display("FAIL %s_fire got send=%b pkt=%h occ=%0d want send=1 pkt=%h occ=0",
               name, Send_out, PACKET_OUT, OCC, exp);
    end
    tick();
    $display("packet %s %h", name, exp);
  endtask

  task automatic test_mono_stall();
    logic [61:0] exp = mk_pkt(16'h0042, 6'h07, 16'hBEEF, 16'h0000);
    send_token(mk_tok(6'h07, 1'b0, 1'b1, 16'h0042, 16'hBEEF), 1'b0, "mono");
    for (int c = 0; c < 3; c++) begin
      drive(mk_tok(6'h08, 1'b0, 1'b1, 16'h0043, 16'h1111), 1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (Send_out !== 1'b1 || PACKET_OUT !== exp || Ack_out !== 1'b0 || OCC !== 5'd0) begin
        n_err++;
        $display("FAIL mono_hold c=%0d got send=%b pkt=%h ack=%b occ=%0d want send=1 pkt=%h ack=0 occ=0",
                 c, Send_out, PACKET_OUT, Ack_out, OCC, exp);
      end
      tick();
    end
    drive('0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (Ack_out !== 1'b1) begin
      n_err++;
      $display("FAIL mono_release_ack got=%b want=1", Ack_out);
    end
    tick();
    drive('0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (Send_out !== 1'b0) begin
      n_err++;
      $display("FAIL mono_drained got=%b want=0", Send_out);
    end
    tick();
  endtask

  task automatic test_collide_flush();
    logic [39:0] blk = mk_tok(6'h05, 1'b0, 1'b0, 16'h0023, 16'h5555);
    send_token(mk_tok(6'h04, 1'b0, 1'b0, 16'h0013, 16'h4444), 1'b1, "coll_first");
    for (int c = 0; c < 3; c++) begin
      drive(blk, 1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (COLLIDE !== 1'b1 || Ack_out !== 1'b0 || OCC !== 5'd1) begin
        n_err++;
        $display("FAIL collide c=%0d got col=%b ack=%b occ=%0d want col=1 ack=0 occ=1",
                 c, COLLIDE, Ack_out, OCC);
      end
      tick();
    end
    drive(blk, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    for (int c = 0; c < DEPTH; c++) begin
      drive(blk, 1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (Ack_out !== 1'b0 || OCC !== 5'd0 || COLLIDE !== m_collide()) begin
        n_err++;
        $display("FAIL flush_init c=%0d got ack=%b occ=%0d col=%b want ack=0 occ=0 col=%b",
                 c, Ack_out, OCC, COLLIDE, m_collide());
      end
      tick();
    end
    send_token(blk, 1'b1, "coll_retry");
    drive('0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (OCC !== 5'd1 || Send_out !== 1'b0) begin
      n_err++;
      $display("FAIL flush_stored got occ=%0d send=%b want occ=1 send=0", OCC, Send_out);
    end
    tick();
    send_token(mk_tok(6'h06, 1'b1, 1'b0, 16'h0023, 16'h6666), 1'b1, "coll_partner");
    drive('0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (PACKET_OUT !== mk_pkt(16'h0023, 6'h05, 16'h5555, 16'h6666) || Send_out !== 1'b1) begin
      n_err++;
      $display("FAIL flush_partner got send=%b pkt=%h", Send_out, PACKET_OUT);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] tags [DEPTH];
    logic [15:0] dl [DEPTH];
    logic [15:0] dr [DEPTH];
    logic [5:0]  op [DEPTH];
    logic [61:0] exp [DEPTH];
    for (int i = 0; i < DEPTH; i++) begin
      tags[i] = {12'($urandom), 4'(i)};
      dl[i]   = 16'($urandom);
      dr[i]   = 16'($urandom);
      op[i]   = 6'($urandom);
      exp[i]  = mk_pkt(tags[i], op[i], dl[i], dr[i]);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(mk_tok(op[i], 1'b0, 1'b0, tags[i], dl[i]), 1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (Ack_out !== 1'b1) begin
        n_err++;
        $display("FAIL stream_left i=%0d got ack=%b want 1", i, Ack_out);
      end
      tick();
    end
    drive('0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (OCC !== 5'd16 || Send_out !== 1'b0) begin
      n_err++;
      $display("FAIL stream_full got occ=%0d send=%b want occ=16 send=0", OCC, Send_out);
    end
    tick();
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) drive(mk_tok(6'h00, 1'b1, 1'b0, tags[i], dr[i]), 1'b1, 1'b1, 1'b0, 1'b0);
      else           drive('0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (i < DEPTH) begin
        n_cmp++;
        if (Ack_out !== 1'b1) begin
          n_err++;
          $display("FAIL stream_right i=%0d got ack=%b want 1", i, Ack_out);
        end
      end
      if (i > 0) begin
        n_cmp++;
        if (Send_out !== 1'b1 || PACKET_OUT !== exp[i-1]) begin
          n_err++;
          $display("FAIL stream_pkt i=%0d got send=%b pkt=%h want send=1 pkt=%h",
                   i - 1, Send_out, PACKET_OUT, exp[i-1]);
        end else begin
          $display("packet stream %0d %h", i - 1, PACKET_OUT);
        end
      end
      tick();
    end
    drive('0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (OCC !== 5'd0 || Send_out !== 1'b0) begin
      n_err++;
      $display("FAIL stream_empty got occ=%0d send=%b want occ=0 send=0", OCC, Send_out);
    end
    tick();
  endtask

  task automatic test_random();
    logic [15:0] tag;
    logic [39:0] tok;
    for (int c = 0; c < 600; c++) begin
      tag = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) tag[4] = 1'b1;
      tok = mk_tok(6'($urandom), 1'($urandom), 1'($urandom_range(0, 7) == 0), tag, 16'($urandom));
      drive(tok, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 79) == 0), 1'b0);
      n_cmp++;
      if (Ack_out !== m_ack() || COLLIDE !== m_collide()) begin
        n_err++;
        $display("FAIL rnd_hs c=%0d got ack=%b col=%b want ack=%b col=%b",
                 c, Ack_out, COLLIDE, m_ack(), m_collide());
      end
      n_cmp++;
      if (Send_out !== m_out_v || OCC !== (DL+1)'(m_occ())) begin
        n_err++;
        $display("FAIL rnd_state c=%0d got send=%b occ=%0d want send=%b occ=%0d",
                 c, Send_out, OCC, m_out_v, m_occ());
      end
      if (m_out_v) begin
        n_cmp++;
        if (PACKET_OUT !== m_out) begin
          n_err++;
          $display("FAIL rnd_pkt c=%0d got=%h want=%h", c, PACKET_OUT, m_out);
        end
      end
      if (Send_in && m_ack()) $display("token rnd %0d %h accepted", c, tok);
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) m_valid[k] = 1'b0;
    test_reset();
    test_pair(1'b0, 16'h0013, 6'h01, 16'h1234, 16'h0F0F, "pair_lr");
    test_pair(1'b1, 16'h0005, 6'h02, 16'hAAAA, 16'hBBBB, "pair_rl");
    test_mono_stall();
    test_collide_flush();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
